uart_rx_fifo: RTL and testbench

// Receive buffer between the uart receiver (rx_data/rx_done) and its consumers (io block, bootloader).

---
 rtl/uart_rx_fifo.sv | 70 +++++++
 tb/tb_uart_rx_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive FIFO behind the uart receiver
// Buffers rx_done bytes until the consumer pops them; sticky overrun marks dropped bytes.
module uart_rx_fifo #(
   parameter int ADDR_W = 4,
   parameter int THRESH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_done,
   input  logic              rd,
   input  logic              clr_overrun,
   output logic [7:0]        dout,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              overrun,
   output logic              irq
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count_q;
   logic              push;
   logic              pop;
   logic              drop;

   assign empty = (count_q == '0);
   assign full  = (count_q == (ADDR_W+1)'(DEPTH));
   assign irq   = (count_q >= (ADDR_W+1)'(THRESH));
   assign count = count_q;
   assign dout  = empty ? 8'h00 : mem[rd_ptr];

   // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
   assign pop  = rd & ~empty;
   assign push = rx_done & (~full | rd);
   assign drop = rx_done & full & ~rd;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= rx_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         overrun <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count_q <= count_q + 1'b1;
         else if (pop && !push)
            count_q <= count_q - 1'b1;
         // Set wins over a coincident clear so no drop goes unreported.
         if (drop)
            overrun <= 1'b1;
         else if (clr_overrun)
            overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
// Queue model tracks expected contents; vector table plus directed sequences.
module tb_uart_rx_fifo;

   localparam int DEPTH  = 16;
   localparam int THRESH = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       rd;
   logic       clr_overrun;
   logic [7:0] dout;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       overrun;
   logic       irq;

   int n_vec  = 0;
   int n_miss = 0;

   logic [7:0] m_q[$];
   logic       m_ovr;

   typedef struct {
      logic       d;
      logic [7:0] b;
      logic       r;
      logic       c;
      logic [4:0] e_count;
      logic [7:0] e_dout;
      logic       e_empty;
      logic       e_full;
      logic       e_ovr;
      logic       e_irq;
   } vec_t;

   vec_t tbl[6];

   uart_rx_fifo #(.ADDR_W(4), .THRESH(THRESH)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_done     (rx_done),
      .rd          (rd),
      .clr_overrun (clr_overrun),
      .dout        (dout),
      .empty       (empty),
      .full        (full),
      .count       (count),
      .overrun     (overrun),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      int sz;
      sz = m_q.size();
      chk({tag, "_count"},   16'(count),   16'(sz));
      chk({tag, "_empty"},   16'(empty),   16'(sz == 0));
      chk({tag, "_full"},    16'(full),    16'(sz == DEPTH));
      chk({tag, "_overrun"}, 16'(overrun), 16'(m_ovr));
      chk({tag, "_irq"},     16'(irq),     16'(sz >= THRESH));
      chk({tag, "_dout"},    16'(dout),    16'((sz == 0) ? 8'h00 : m_q[0]));
   endtask

   // Drive one cycle of strobes; the scoreboard checks the popped head before the edge.
   task automatic step(input logic d, input logic [7:0] b, input logic r, input logic c);
      logic push_ok;
      logic pop_ok;
      rx_done     = d;
      rx_data     = b;
      rd          = r;
      clr_overrun = c;
      pop_ok  = r && (m_q.size() > 0);
      push_ok = d && ((m_q.size() < DEPTH) || r);
      if (pop_ok) begin
         chk("sb_pop", 16'(dout), 16'(m_q[0]));
         m_q.delete(0);
      end
      if (push_ok)
         m_q.push_back(b);
      if (d && !push_ok)
         m_ovr = 1'b1;
      else if (c)
         m_ovr = 1'b0;
      @(posedge clk);
      #1;
      rx_done     = 1'b0;
      rd          = 1'b0;
      clr_overrun = 1'b0;
      check_model("step");
   endtask

   initial begin
      rst         = 1'b1;
      rx_data     = 8'h00;
      rx_done     = 1'b0;
      rd          = 1'b0;
      clr_overrun = 1'b0;
      m_ovr       = 1'b0;

      //            d     b      r     c     cnt   dout   emp   full  ovr   irq
      tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 5'd1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 8'h3C, 1'b1, 1'b0, 5'd1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      check_model("reset");
      rst = 1'b0;

      // Basic push/pop, simultaneous push+pop on empty, rd on empty
      for (int i = 0; i < 6; i++) begin
         step(tbl[i].d, tbl[i].b, tbl[i].r, tbl[i].c);
         chk("tbl_count", 16'(count),   16'(tbl[i].e_count));
         chk("tbl_dout",  16'(dout),    16'(tbl[i].e_dout));
         chk("tbl_empty", 16'(empty),   16'(tbl[i].e_empty));
         chk("tbl_full",  16'(full),    16'(tbl[i].e_full));
         chk("tbl_ovr",   16'(overrun), 16'(tbl[i].e_ovr));
         chk("tbl_irq",   16'(irq),     16'(tbl[i].e_irq));
      end

      // Fill to full with irq threshold, then overflow
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 8'(i), 1'b0, 1'b0);
         chk("irq_thresh", 16'(irq), 16'((i + 1) >= THRESH));
      end
      chk("full_at_16", 16'(full), 16'(1));
      step(1'b1, 8'hFF, 1'b0, 1'b0);
      chk("overrun_set", 16'(overrun), 16'(1));
      chk("count_after_drop", 16'(count), 16'(DEPTH));
      for (int i = 0; i < DEPTH; i++) begin
         chk("drain_order", 16'(dout), 16'(i));
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("overrun_clr", 16'(overrun), 16'(0));

      // Push+pop while full
      for (int i = 0; i < DEPTH; i++)
         step(1'b1, 8'(i), 1'b0, 1'b0);
      step(1'b1, 8'h77, 1'b1, 1'b0);
      chk("full_pushpop_count", 16'(count), 16'(DEPTH));
      chk("full_pushpop_ovr", 16'(overrun), 16'(0));
      // Drop coincident with clear keeps overrun set
      step(1'b1, 8'hEE, 1'b0, 1'b1);
      chk("drop_beats_clr", 16'(overrun), 16'(1));
      step(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < DEPTH - 1; i++)
         step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("last_is_77", 16'(dout), 16'h77);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Pointer wrap under steady push+pop traffic
      for (int i = 0; i < 3; i++)
         step(1'b1, 8'($urandom_range(255)), 1'b0, 1'b0);
      for (int i = 0; i < 40; i++)
         step(1'b1, 8'($urandom_range(255)), 1'b1, 1'b0);
      while (m_q.size() > 0)
         step(1'b0, 8'h00, 1'b1, 1'b0);

      // Asynchronous reset mid-operation with overrun set and 5 bytes held
      for (int i = 0; i < DEPTH + 1; i++)
         step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      for (int i = 0; i < DEPTH - 5; i++)
         step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("pre_rst_count", 16'(count), 16'(5));
      rst = 1'b1;
      #1;
      m_q.delete();
      m_ovr = 1'b0;
      check_model("async_rst");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      step(1'b1, 8'h5A, 1'b0, 1'b0);
      chk("post_rst_dout", 16'(dout), 16'h5A);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
